ysyx_22050854_writeback: RTL and testbench
==========================================

// Module: ysyx_22050854_writeback
// PURPOSE
//  Writeback stage of the 64-bit RV64 core. Single-entry pipeline register between MEM and the register file.
//  Captures the MEM result and extracts/extends load data (LB/LH/LW/LD/LBU/LHU/LWU).
//  Drives the register-file write port (wen/waddr/wdata) and a same-cycle forwarding port for EX bypass.
//  Also provides a commit pulse and a retired-instruction counter.
// PARAMETERS
//  XLEN     64  datapath width; only 64 is supported
//  CNT_W    64  width of retire counter
// PORTS
//  clk            in   1      clock, all state updates on rising edge
//  rst            in   1      synchronous reset, active-high
//  mem_valid      in   1      MEM presents an instruction
//  mem_ready      out  1      WB can accept this cycle
//  mem_pc         in   64     PC of MEM instruction
//  mem_rd         in   5      destination register
//  mem_rd_wen     in   1      instruction writes rd
//  mem_is_load    in   1      result comes from memory, not ALU
//  mem_funct3     in   3      load funct3 (000 LB,001 LH,010 LW,011 LD,100 LBU,101 LHU,110 LWU)
//  mem_addr_lo    in   3      load byte address [2:0] within doubleword
//  mem_rdata      in   64     raw aligned doubleword from data memory
//  mem_alu_res    in   64     ALU result
//  wb_stall       in   1      hold WB entry (e.g. difftest/debug hold)
//  rf_wen         out  1      register-file write enable
//  rf_waddr       out  5      register-file write address
//  rf_wdata       out  64     register-file write data
//  fwd_valid      out  1      fwd_rd/fwd_data are a pending write
//  fwd_rd         out  5      forwarding destination
//  fwd_data       out  64     forwarding data (= rf_wdata)
//  commit_valid   out  1      one-cycle pulse, instruction retired last cycle
//  commit_pc      out  64     PC of retired instruction
//  retire_cnt     out  CNT_W  retired instruction count
//  misalign_err   out  1      sticky: misaligned or illegal-funct3 load seen
// BEHAVIOUR
//  - State: wb_valid_q plus entry regs {pc_q, rd_q, wen_q, data_q}. States EMPTY (valid_q=0) / FULL (valid_q=1).
//  - mem_ready = !wb_valid_q | !wb_stall (combinational). Accept when mem_valid & mem_ready.
//  - retire = wb_valid_q & !wb_stall. Retire and accept in the same cycle allowed: entry replaced, stays FULL.
//  - FULL->EMPTY on retire without accept; EMPTY->FULL on accept; FULL & wb_stall: hold, no write.
//  - data_q captured at accept: mem_is_load ? ext(mem_rdata, mem_funct3, mem_addr_lo) : mem_alu_res.
//  - Load extraction: byte = rdata[8*lo +: 8]; half = rdata[16*lo[2:1] +: 16]; word = rdata[32*lo[2] +: 32].
//  - Signed forms sign-extend to 64; U forms zero-extend; LD passes 64 bits.
//  - Misaligned (LH/LHU lo[0]!=0; LW/LWU lo[1:0]!=0; LD lo!=0) or funct3=111: data_q=0, misalign_err<=1 (sticky until rst).
//  - rf_wen = retire & wen_q & (rd_q!=0). rf_waddr=rd_q, rf_wdata=data_q (comb from regs). Write to x0 never asserted.
//  - fwd_valid = wb_valid_q & wen_q & (rd_q!=0), independent of wb_stall; fwd_rd=rd_q, fwd_data=data_q.
//  - commit_valid registered: <= retire; commit_pc <= pc_q on retire. Latency: accept at edge N, write at N+1 edge
//    (if not stalled), commit_valid high during cycle after that write.
//  - retire_cnt += 1 on every retire (incl. rd_wen=0 and rd=x0); wraps modulo 2^CNT_W.
//  - rst: wb_valid_q=0, commit_valid=0, commit_pc=0, retire_cnt=0, misalign_err=0, entry regs=0.
//    Hence rf_wen=0, fwd_valid=0, mem_ready=1 during/after reset. Entry in flight at rst is dropped, never written.
//  - mem_valid ignored while rst high.
// TESTING
//  1. ALU: mem_valid, rd=5, alu=0x1234 -> next cycle rf_wen=1,waddr=5,wdata=0x1234; following cycle commit_valid=1, retire_cnt=1.
//  2. LB lo=3, rdata=0x0000_0000_8000_0000 -> wdata=0xFFFF_FFFF_FFFF_FF80; LBU same -> 0x80; LWU lo=4, rdata=0xDEADBEEF_00000000 -> 0xDEADBEEF.
//  3. rd=0 wen=1 -> rf_wen=0, fwd_valid=0, retire_cnt still increments.
//  4. wb_stall=1 for 3 cycles with entry FULL -> mem_ready=0, rf_wen=0, fwd_valid=1; release -> single write, back-to-back accept same cycle.
//  5. LH lo=1 -> data 0, misalign_err=1 stays set over later good loads; funct3=111 also sets it.
//  6. rst asserted while FULL -> no rf_wen, retire_cnt=0, mem_ready=1; retire_cnt preset near 2^64-1 wraps to 0.

Source files
------------

// File: rtl/ysyx_22050854_writeback.sv
// ysyx_22050854_writeback
// Writeback stage of the RV64 core: a single-entry pipeline register between
// MEM and the register file.
// - Captures the MEM result. For loads it extracts the addressed byte, half,
//   word or doubleword and sign- or zero-extends it.
// - Drives the register-file write port and a forwarding port for EX bypass.
// - Emits a registered commit pulse and keeps a retired-instruction counter.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   mem_valid / mem_ready     MEM handshake (ready is combinational)
//   mem_pc, mem_rd, mem_rd_wen, mem_is_load, mem_funct3, mem_addr_lo,
//   mem_rdata, mem_alu_res    MEM instruction fields and raw result data
//   wb_stall                  holds the current entry in WB
//   rf_wen/rf_waddr/rf_wdata  register-file write port
//   fwd_valid/fwd_rd/fwd_data bypass of the pending write
//   commit_valid/commit_pc    one-cycle pulse after an instruction retires
//   retire_cnt                retired instruction count (wraps)
//   misalign_err              sticky flag for misaligned or illegal loads
module ysyx_22050854_writeback #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_valid,
  output logic             mem_ready,
  input  logic [XLEN-1:0]  mem_pc,
  input  logic [4:0]       mem_rd,
  input  logic             mem_rd_wen,
  input  logic             mem_is_load,
  input  logic [2:0]       mem_funct3,
  input  logic [2:0]       mem_addr_lo,
  input  logic [XLEN-1:0]  mem_rdata,
  input  logic [XLEN-1:0]  mem_alu_res,
  input  logic             wb_stall,
  output logic             rf_wen,
  output logic [4:0]       rf_waddr,
  output logic [XLEN-1:0]  rf_wdata,
  output logic             fwd_valid,
  output logic [4:0]       fwd_rd,
  output logic [XLEN-1:0]  fwd_data,
  output logic             commit_valid,
  output logic [XLEN-1:0]  commit_pc,
  output logic [CNT_W-1:0] retire_cnt,
  output logic             misalign_err
);

  logic             wb_valid_reg;
  logic [XLEN-1:0]  pc_reg;
  logic [4:0]       rd_reg;
  logic             wen_reg;
  logic [XLEN-1:0]  data_reg;
  logic             commit_valid_reg;
  logic [XLEN-1:0]  commit_pc_reg;
  logic [CNT_W-1:0] retire_cnt_reg;
  logic             misalign_reg;

  logic             accept;
  logic             retire;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;
  logic [31:0]      ld_word;
  logic             ld_bad;
  logic [XLEN-1:0]  ld_data;
  logic [XLEN-1:0]  data_next;

  // Reset masks the handshake and the write port so that an entry in flight
  // when rst rises is dropped rather than written.
  assign mem_ready = rst | ~wb_valid_reg | ~wb_stall;
  assign retire    = ~rst & wb_valid_reg & ~wb_stall;
  assign accept    = ~rst & mem_valid & mem_ready;

  // Lane selection within the aligned doubleword.
  assign ld_byte = mem_rdata[{mem_addr_lo, 3'b000} +: 8];
  assign ld_half = mem_rdata[{mem_addr_lo[2:1], 4'b0000} +: 16];
  assign ld_word = mem_rdata[{mem_addr_lo[2], 5'b00000} +: 32];

  always_comb begin
    ld_bad  = 1'b0;
    ld_data = '0;
    case (mem_funct3)
      3'b000: ld_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b100: ld_data = {{(XLEN-8){1'b0}}, ld_byte};
      3'b001, 3'b101: begin
        ld_bad = mem_addr_lo[0];
        if (mem_funct3[2]) ld_data = {{(XLEN-16){1'b0}}, ld_half};
        else               ld_data = {{(XLEN-16){ld_half[15]}}, ld_half};
      end
      3'b010, 3'b110: begin
        ld_bad = (mem_addr_lo[1:0] != 2'b00);
        if (mem_funct3[2]) ld_data = {{(XLEN-32){1'b0}}, ld_word};
        else               ld_data = {{(XLEN-32){ld_word[31]}}, ld_word};
      end
      3'b011: begin
        ld_bad  = (mem_addr_lo != 3'b000);
        ld_data = mem_rdata;
      end
      default: ld_bad = 1'b1;  // funct3 = 111 has no load encoding
    endcase
    // A faulting load writes zero rather than partially selected data.
    if (ld_bad) ld_data = '0;
  end

  assign data_next = mem_is_load ? ld_data : mem_alu_res;

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid_reg     <= 1'b0;
      pc_reg           <= '0;
      rd_reg           <= '0;
      wen_reg          <= 1'b0;
      data_reg         <= '0;
      commit_valid_reg <= 1'b0;
      commit_pc_reg    <= '0;
      retire_cnt_reg   <= '0;
      misalign_reg     <= 1'b0;
    end else begin
      // Accept wins over retire: a simultaneous retire+accept refills the slot.
      if (accept) begin
        wb_valid_reg <= 1'b1;
        pc_reg       <= mem_pc;
        rd_reg       <= mem_rd;
        wen_reg      <= mem_rd_wen;
        data_reg     <= data_next;
      end else if (retire) begin
        wb_valid_reg <= 1'b0;
      end
      commit_valid_reg <= retire;
      if (retire) begin
        commit_pc_reg  <= pc_reg;
        retire_cnt_reg <= retire_cnt_reg + CNT_W'(1);
      end
      if (accept && mem_is_load && ld_bad) misalign_reg <= 1'b1;
    end
  end

  // x0 is never written and never forwarded.
  assign rf_wen       = retire & wen_reg & (rd_reg != 5'd0);
  assign rf_waddr     = rd_reg;
  assign rf_wdata     = data_reg;
  assign fwd_valid    = ~rst & wb_valid_reg & wen_reg & (rd_reg != 5'd0);
  assign fwd_rd       = rd_reg;
  assign fwd_data     = data_reg;
  assign commit_valid = commit_valid_reg;
  assign commit_pc    = commit_pc_reg;
  assign retire_cnt   = retire_cnt_reg;
  assign misalign_err = misalign_reg;

endmodule

// File: tb/tb_ysyx_22050854_writeback.sv
module tb_ysyx_22050854_writeback;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        mem_valid = 1'b0;
  logic [63:0] mem_pc = '0;
  logic [4:0]  mem_rd = '0;
  logic        mem_rd_wen = 1'b0;
  logic        mem_is_load = 1'b0;
  logic [2:0]  mem_funct3 = '0;
  logic [2:0]  mem_addr_lo = '0;
  logic [63:0] mem_rdata = '0;
  logic [63:0] mem_alu_res = '0;
  logic        wb_stall = 1'b0;

  logic        mem_ready, rf_wen, fwd_valid, commit_valid, misalign_err;
  logic [4:0]  rf_waddr, fwd_rd;
  logic [63:0] rf_wdata, fwd_data, commit_pc, retire_cnt;

  // Narrow-counter instance fed the same stream to exercise counter wrap.
  logic        s_mem_ready, s_rf_wen, s_fwd_valid, s_commit_valid, s_misalign_err;
  logic [4:0]  s_rf_waddr, s_fwd_rd;
  logic [63:0] s_rf_wdata, s_fwd_data, s_commit_pc;
  logic [3:0]  s_retire_cnt;

  ysyx_22050854_writeback #(.XLEN(64), .CNT_W(64)) u_dut (
    .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_pc(mem_pc), .mem_rd(mem_rd), .mem_rd_wen(mem_rd_wen),
    .mem_is_load(mem_is_load), .mem_funct3(mem_funct3), .mem_addr_lo(mem_addr_lo),
    .mem_rdata(mem_rdata), .mem_alu_res(mem_alu_res), .wb_stall(wb_stall),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .commit_valid(commit_valid), .commit_pc(commit_pc),
    .retire_cnt(retire_cnt), .misalign_err(misalign_err)
  );

  ysyx_22050854_writeback #(.XLEN(64), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_ready(s_mem_ready),
    .mem_pc(mem_pc), .mem_rd(mem_rd), .mem_rd_wen(mem_rd_wen),
    .mem_is_load(mem_is_load), .mem_funct3(mem_funct3), .mem_addr_lo(mem_addr_lo),
    .mem_rdata(mem_rdata), .mem_alu_res(mem_alu_res), .wb_stall(wb_stall),
    .rf_wen(s_rf_wen), .rf_waddr(s_rf_waddr), .rf_wdata(s_rf_wdata),
    .fwd_valid(s_fwd_valid), .fwd_rd(s_fwd_rd), .fwd_data(s_fwd_data),
    .commit_valid(s_commit_valid), .commit_pc(s_commit_pc),
    .retire_cnt(s_retire_cnt), .misalign_err(s_misalign_err)
  );

  int passed = 0;
  int total  = 0;

  // Reference model: one optional pending instruction plus counters.
  logic        m_valid = 1'b0;
  logic [63:0] m_pc = '0;
  logic [4:0]  m_rd = '0;
  logic        m_wen = 1'b0;
  logic [63:0] m_data = '0;
  logic        m_commit = 1'b0;
  logic [63:0] m_commit_pc = '0;
  logic [63:0] m_cnt = '0;
  logic        m_mis = 1'b0;
  logic [63:0] pc_ctr = 64'h8000_0000;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Load result from the access size and the address offset, in plain arithmetic.
  // Bit 64 of the result flags a misaligned/illegal access.
  function automatic logic [64:0] ref_load(input logic [2:0] f3, input logic [2:0] lo,
                                           input logic [63:0] raw);
    int nbytes;
    logic [63:0] v, mask;
    nbytes = 1 << f3[1:0];
    if (f3 == 3'b111 || (int'(lo) % nbytes) != 0) return {1'b1, 64'd0};
    v = raw >> (8 * int'(lo));
    mask = (nbytes == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nbytes)) - 64'd1);
    v = v & mask;
    if (!f3[2] && nbytes < 8 && v[8 * nbytes - 1]) v = v | ~mask;
    return {1'b0, v};
  endfunction

  task automatic compare_all();
    logic ready, ret;
    ready = rst || !m_valid || !wb_stall;
    ret   = !rst && m_valid && !wb_stall;
    check("mem_ready", mem_ready, ready);
    check("rf_wen", rf_wen, ret && m_wen && m_rd != 0);
    check("rf_waddr", rf_waddr, m_rd);
    check("rf_wdata", rf_wdata, m_data);
    check("fwd_valid", fwd_valid, !rst && m_valid && m_wen && m_rd != 0);
    check("fwd_rd", fwd_rd, m_rd);
    check("fwd_data", fwd_data, m_data);
    check("commit_valid", commit_valid, m_commit);
    check("commit_pc", commit_pc, m_commit_pc);
    check("retire_cnt", retire_cnt, m_cnt);
    check("misalign_err", misalign_err, m_mis);
    check("retire_cnt_w4", s_retire_cnt, m_cnt % 16);
  endtask

  task automatic model_edge();
    logic ready, ret, acc;
    logic [64:0] r;
    ready = rst || !m_valid || !wb_stall;
    ret   = !rst && m_valid && !wb_stall;
    acc   = !rst && mem_valid && ready;
    if (rst) begin
      m_valid = 0; m_pc = 0; m_rd = 0; m_wen = 0; m_data = 0;
      m_commit = 0; m_commit_pc = 0; m_cnt = 0; m_mis = 0;
    end else begin
      m_commit = ret;
      if (ret) begin
        m_commit_pc = m_pc;
        m_cnt = m_cnt + 1;
        $display("retire pc=%h rd=%0d wen=%0d data=%h", m_pc, m_rd, m_wen, m_data);
      end
      if (acc) begin
        r = mem_is_load ? ref_load(mem_funct3, mem_addr_lo, mem_rdata) : {1'b0, mem_alu_res};
        m_valid = 1; m_pc = mem_pc; m_rd = mem_rd; m_wen = mem_rd_wen; m_data = r[63:0];
        if (r[64]) m_mis = 1;
      end else if (ret) begin
        m_valid = 0;
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic [4:0] rd, input logic wen, input logic ld,
                       input logic [2:0] f3, input logic [2:0] lo,
                       input logic [63:0] raw, input logic [63:0] alu);
    mem_valid = 1; mem_rd = rd; mem_rd_wen = wen; mem_is_load = ld;
    mem_funct3 = f3; mem_addr_lo = lo; mem_rdata = raw; mem_alu_res = alu;
    mem_pc = pc_ctr; pc_ctr = pc_ctr + 4;
  endtask

  task automatic idle();
    mem_valid = 0; wb_stall = 0;
  endtask

  initial begin
    // Reset
    rst = 1;
    cycle(); cycle();
    rst = 0;
    #1;
    check("reset_ready", mem_ready, 1);
    check("reset_rf_wen", rf_wen, 0);
    check("reset_cnt", retire_cnt, 0);

    // 1. ALU result
    drive(5'd5, 1, 0, 3'd0, 3'd0, 64'd0, 64'h1234);
    cycle();
    idle(); #1;
    check("alu_wen", rf_wen, 1);
    check("alu_waddr", rf_waddr, 5);
    check("alu_wdata", rf_wdata, 64'h1234);
    cycle(); #1;
    check("alu_commit", commit_valid, 1);
    check("alu_commit_pc", commit_pc, 64'h8000_0000);
    check("alu_cnt", retire_cnt, 1);

    // 2. Load extraction, back to back
    drive(5'd6, 1, 1, 3'b000, 3'd3, 64'h0000_0000_8000_0000, 64'd0);
    cycle();
    drive(5'd6, 1, 1, 3'b100, 3'd3, 64'h0000_0000_8000_0000, 64'd0);
    #1; check("lb", rf_wdata, 64'hFFFF_FFFF_FFFF_FF80);
    cycle();
    drive(5'd6, 1, 1, 3'b110, 3'd4, 64'hDEAD_BEEF_0000_0000, 64'd0);
    #1; check("lbu", rf_wdata, 64'h80);
    cycle();
    idle(); #1; check("lwu", rf_wdata, 64'hDEAD_BEEF);
    cycle();

    // 3. Write to x0
    drive(5'd0, 1, 0, 3'd0, 3'd0, 64'd0, 64'h5);
    cycle();
    idle(); #1;
    check("x0_wen", rf_wen, 0);
    check("x0_fwd", fwd_valid, 0);
    cycle(); #1;
    check("x0_cnt", retire_cnt, 5);

    // 4. Stall with a waiting successor
    drive(5'd7, 1, 0, 3'd0, 3'd0, 64'd0, 64'h77);
    cycle();
    drive(5'd8, 1, 0, 3'd0, 3'd0, 64'd0, 64'h88);
    wb_stall = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_ready", mem_ready, 0);
      check("stall_wen", rf_wen, 0);
      check("stall_fwd", fwd_valid, 1);
      cycle();
    end
    wb_stall = 0; #1;
    check("release_wen", rf_wen, 1);
    check("release_data", rf_wdata, 64'h77);
    check("release_ready", mem_ready, 1);
    cycle();
    idle(); #1;
    check("next_waddr", rf_waddr, 8);
    check("next_data", rf_wdata, 64'h88);
    cycle();

    // 5. Misaligned load is sticky across good loads
    drive(5'd9, 1, 1, 3'b001, 3'd1, {$urandom, $urandom}, 64'd0);
    cycle();
    idle(); #1;
    check("lh_mis_data", rf_wdata, 0);
    check("lh_mis_flag", misalign_err, 1);
    cycle();
    drive(5'd10, 1, 1, 3'b011, 3'd0, 64'h0123_4567_89AB_CDEF, 64'd0);
    cycle();
    idle(); #1;
    check("ld_data", rf_wdata, 64'h0123_4567_89AB_CDEF);
    check("ld_sticky", misalign_err, 1);
    cycle();

    // 6. Reset while full, then funct3=111
    drive(5'd11, 1, 0, 3'd0, 3'd0, 64'd0, 64'hABC);
    cycle();
    rst = 1; #1;
    check("rst_full_wen", rf_wen, 0);
    check("rst_full_ready", mem_ready, 1);
    cycle();
    rst = 0; idle(); #1;
    check("post_rst_cnt", retire_cnt, 0);
    check("post_rst_fwd", fwd_valid, 0);
    check("post_rst_mis", misalign_err, 0);
    check("post_rst_wen", rf_wen, 0);
    drive(5'd12, 1, 1, 3'b111, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
    cycle();
    idle(); #1;
    check("f3_111_mis", misalign_err, 1);
    check("f3_111_data", rf_wdata, 0);
    cycle();

    // Counter wrap on the 4-bit instance: 15 more retires reach 16.
    for (int i = 0; i < 15; i++) begin
      drive(5'(i + 1), 1, 0, 3'd0, 3'd0, 64'd0, 64'(i));
      cycle();
    end
    idle();
    cycle(); #1;
    check("wrap_w4", s_retire_cnt, 0);
    check("wrap_w64", retire_cnt, 16);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      rst         = ($urandom_range(0, 49) == 0);
      wb_stall    = ($urandom_range(0, 3) == 0);
      mem_valid   = $urandom_range(0, 1);
      mem_rd      = 5'($urandom);
      mem_rd_wen  = $urandom_range(0, 1);
      mem_is_load = $urandom_range(0, 1);
      mem_funct3  = 3'($urandom);
      mem_addr_lo = 3'($urandom);
      mem_rdata   = {$urandom, $urandom};
      mem_alu_res = {$urandom, $urandom};
      mem_pc      = {$urandom, $urandom};
      cycle();
    end
    rst = 0; idle();
    cycle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
